// File: rtl/seq_divider_32b.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next operation completes.
module seq_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] divisor_p0;
    logic [WIDTH-1:0] work_q_p0;
    logic [WIDTH:0]   prem_p0;
    logic [CNT_W-1:0] count_p0;

    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] next_q;

    // One restoring step; the borrow out of the (WIDTH+1)-bit trial decides the quotient bit.
    function automatic logic [2*WIDTH:0] restore_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH]) begin
            return {trial, q[WIDTH-2:0], 1'b1};
        end
        return {shifted, q[WIDTH-2:0], 1'b0};
    endfunction

    assign {next_rem, next_q} = restore_step(prem_p0, work_q_p0, divisor_p0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            divisor_p0  <= '0;
            work_q_p0   <= '0;
            prem_p0     <= '0;
            count_p0    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            state      <= CALC;
                            busy       <= 1'b1;
                            divisor_p0 <= divisor;
                            work_q_p0  <= dividend;
                            prem_p0    <= '0;
                            count_p0   <= '0;
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                // iteration stage: working registers advance one quotient bit
                CALC: begin
                    prem_p0   <= next_rem;
                    work_q_p0 <= next_q;
                    count_p0  <= count_p0 + 1'b1;
                    if (count_p0 == LAST) begin
                        quotient    <= next_q;
                        remainder   <= next_rem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32b.sv
// Self-checking bench for seq_divider_32b: directed scenarios plus random
// operands checked against a plain-arithmetic division model.
module tb_seq_divider_32b;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider_32b #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issues one start pulse and waits (bounded) for done; lat counts cycles from start.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output int busy_n, output logic got);
        got = 1'b0; lat = 0; busy_n = 0; q = '0; r = '0; z = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 100) begin
            if (busy) busy_n++;
            if (done) begin
                got = 1'b1; q = quotient; r = remainder; z = div_by_zero;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b dbz=%b q=%h r=%h exp all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] q, r; logic z, got; int lat, bn;
        run_op(32'd100, 32'd7, q, r, z, lat, bn, got);
        checks++;
        if (!got || lat != 33) begin
            failures++;
            $display("FAIL basic_latency got done=%b lat=%0d exp done=1 lat=33", got, lat);
        end
        checks++;
        if (bn != 32) begin
            failures++;
            $display("FAIL basic_busy_cycles got %0d exp 32", bn);
        end
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d z=%b exp q=14 r=2 z=0", q, r, z);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got q=%0d r=%0d done=%b exp q=14 r=2 done=0",
                     quotient, remainder, done);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [31:0] qv [3];
        logic [31:0] rv [3];
        logic [31:0] q, r; logic z, got; int lat, bn;
        av = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        bv = '{32'd1, 32'hFFFF_FFFF, 32'h10};
        qv = '{32'hFFFF_FFFF, 32'd0, 32'h0800_0000};
        rv = '{32'd0, 32'd5, 32'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], q, r, z, lat, bn, got);
            checks++;
            if (!got || q !== qv[i] || r !== rv[i] || z !== 1'b0) begin
                failures++;
                $display("FAIL extreme_%0d got done=%b q=%h r=%h z=%b exp q=%h r=%h z=0",
                         i, got, q, r, z, qv[i], rv[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z, got; int lat, bn;
        run_op(32'h1234, 32'd0, q, r, z, lat, bn, got);
        checks++;
        if (!got || lat != 1 || bn != 0) begin
            failures++;
            $display("FAIL dbz_timing got done=%b lat=%0d busy_cycles=%0d exp 1 1 0", got, lat, bn);
        end
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || z !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result got q=%h r=%h z=%b exp q=ffffffff r=1234 z=1", q, r, z);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_after got done=%b dbz=%b exp 0 1", done, div_by_zero);
        end
        run_op(32'd9, 32'd3, q, r, z, lat, bn, got);
        checks++;
        if (!got || q !== 32'd3 || r !== 32'd0 || z !== 1'b0) begin
            failures++;
            $display("FAIL dbz_followup got done=%b q=%0d r=%0d z=%b exp 3 0 0", got, q, r, z);
        end
    endtask

    task automatic test_inflight();
        logic [31:0] q, r; int ndone;
        ndone = 0; q = '0; r = '0;
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++; q = quotient; r = remainder;
            end
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end
            if (c == 11) start = 1'b0;
        end
        checks++;
        if (ndone != 1 || q !== 32'd100 || r !== 32'd0) begin
            failures++;
            $display("FAIL inflight_ignored got dones=%0d q=%0d r=%0d exp 1 100 0", ndone, q, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er; logic ez; int prev, ndone;
        prev = 0; ndone = 0;
        model(32'd77777, 32'd123, eq, er, ez);
        @(negedge clk);
        start = 1'b1; dividend = 32'd77777; divisor = 32'd123;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                checks++;
                if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                    failures++;
                    $display("FAIL b2b_result got q=%0d r=%0d exp q=%0d r=%0d",
                             quotient, remainder, eq, er);
                end
                if (prev != 0) begin
                    checks++;
                    if (c - prev != 34) begin
                        failures++;
                        $display("FAIL b2b_interval got %0d exp 34", c - prev);
                    end
                end
                prev = c;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 4) begin
            failures++;
            $display("FAIL b2b_count got %0d exp 4", ndone);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r; logic z, got; int lat, bn, ndone;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; dividend = 32'd12345; divisor = 32'd67;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid_async got busy=%b done=%b q=%h r=%h exp all zero",
                     busy, done, quotient, remainder);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d dones exp 0", ndone);
        end
        run_op(32'd12345, 32'd67, q, r, z, lat, bn, got);
        checks++;
        if (!got || q !== 32'd184 || r !== 32'd17 || z !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_rerun got done=%b q=%0d r=%0d exp 184 17", got, q, r);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; logic z, ez, got; int lat, bn, elat;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = a >> $urandom_range(0, 8);
            endcase
            model(a, b, eq, er, ez);
            elat = (b == 32'd0) ? 1 : 33;
            run_op(a, b, q, r, z, lat, bn, got);
            checks++;
            if (!got || lat != elat || q !== eq || r !== er || z !== ez) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h got done=%b lat=%0d q=%h r=%h z=%b exp lat=%0d q=%h r=%h z=%b",
                         i, a, b, got, lat, q, r, z, elat, eq, er, ez);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_inflight();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
